dsp48a1_slice: RTL and testbench

- Behavioural, synthesizable model of a Spartan-6-style DSP48A1 slice: an 18-bit pre-adder, an 18x18 signed multiplier and a 48-bit post-adder/accumulator.
- Each stage has an optional pipeline register.
- Used by the audio FIR/MAC path as P = (D+B)*A, either loaded or accumulated into P.

---
 rtl/dsp48a1_pkg.sv | 19 +
 rtl/dsp48a1_pipe_reg.sv | 29 ++
 rtl/dsp48a1_slice.sv | 142 ++++++++++++++
 tb/tb_dsp48a1_slice.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsp48a1_pkg.sv
// Shared widths and post-adder mux select codes for the DSP48A1 slice model.
package dsp48a1_pkg;

  localparam int A_W = 18;
  localparam int P_W = 48;
  localparam int M_W = 36;
  localparam int R_W = P_W + 1;

  localparam logic [1:0] X_ZERO = 2'b00;
  localparam logic [1:0] X_M    = 2'b01;
  localparam logic [1:0] X_P    = 2'b10;
  localparam logic [1:0] X_DAB  = 2'b11;

  localparam logic [1:0] Z_ZERO = 2'b00;
  localparam logic [1:0] Z_PCIN = 2'b01;
  localparam logic [1:0] Z_P    = 2'b10;
  localparam logic [1:0] Z_C    = 2'b11;

endpackage

// File: rtl/dsp48a1_pipe_reg.sv
// Optional pipeline stage: a register with async clear, sync reset and clock
// enable when EN is nonzero, otherwise a plain wire.
module dsp48a1_pipe_reg #(
  parameter int W  = 18,
  parameter int EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rst,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (EN != 0) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   q <= '0;
        else if (rst) q <= '0;
        else if (ce)  q <= d;
      end
    end else begin : g_pass
      logic unused_ctl;
      assign unused_ctl = ^{clk, rst_n, rst, ce};
      assign q = d;
    end
  endgenerate

endmodule

// File: rtl/dsp48a1_slice.sv
// Spartan-6 style DSP48A1 slice: pre-adder, 18x18 signed multiply, 48-bit
// post-adder. Define DSP48A1_CASCADE_EN to add the PCIN/PCOUT/BCOUT cascade ports.
module dsp48a1_slice
  import dsp48a1_pkg::*;
#(
  parameter int A0REG              = 0,
  parameter int A1REG              = 1,
  parameter int B0REG              = 0,
  parameter int B1REG              = 1,
  parameter int CREG               = 1,
  parameter int DREG               = 1,
  parameter int MREG               = 1,
  parameter int PREG               = 1,
  parameter int OPMODEREG          = 1,
  parameter int CARRYINREG         = 1,
  parameter int CARRYOUTREG        = 1,
  parameter int CARRYINSEL_OPMODE5 = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [A_W-1:0] A,
  input  logic [A_W-1:0] B,
  input  logic [A_W-1:0] D,
  input  logic [P_W-1:0] C,
  input  logic           CARRYIN,
  input  logic [7:0]     OPMODE,
  input  logic           CEA,
  input  logic           CEB,
  input  logic           CEC,
  input  logic           CED,
  input  logic           CEM,
  input  logic           CEP,
  input  logic           CEOPMODE,
  input  logic           CECARRYIN,
  input  logic           RSTA,
  input  logic           RSTB,
  input  logic           RSTC,
  input  logic           RSTD,
  input  logic           RSTM,
  input  logic           RSTP,
  input  logic           RSTOPMODE,
  input  logic           RSTCARRYIN,
  output logic [M_W-1:0] M,
  output logic [P_W-1:0] P,
  output logic           CARRYOUT,
  output logic           CARRYOUTF
`ifdef DSP48A1_CASCADE_EN
  ,
  input  logic [P_W-1:0] PCIN,
  output logic [P_W-1:0] PCOUT,
  output logic [A_W-1:0] BCOUT
`endif
);

  logic [7:0]     op;
  logic [A_W-1:0] a0, a1, b0, b1, b_pre, d_r;
  logic [P_W-1:0] c_r, x, z, p_fb;
  logic [M_W-1:0] m_prod;
  logic           cin_src, cin;
  logic [R_W-1:0] r, xc;

  dsp48a1_pipe_reg #(.W(8), .EN(OPMODEREG)) u_opmode (
    .clk, .rst_n, .rst(RSTOPMODE), .ce(CEOPMODE), .d(OPMODE), .q(op));

  dsp48a1_pipe_reg #(.W(A_W), .EN(A0REG)) u_a0 (
    .clk, .rst_n, .rst(RSTA), .ce(CEA), .d(A), .q(a0));
  dsp48a1_pipe_reg #(.W(A_W), .EN(A1REG)) u_a1 (
    .clk, .rst_n, .rst(RSTA), .ce(CEA), .d(a0), .q(a1));

  dsp48a1_pipe_reg #(.W(A_W), .EN(DREG)) u_d (
    .clk, .rst_n, .rst(RSTD), .ce(CED), .d(D), .q(d_r));
  dsp48a1_pipe_reg #(.W(P_W), .EN(CREG)) u_c (
    .clk, .rst_n, .rst(RSTC), .ce(CEC), .d(C), .q(c_r));

  dsp48a1_pipe_reg #(.W(A_W), .EN(B0REG)) u_b0 (
    .clk, .rst_n, .rst(RSTB), .ce(CEB), .d(B), .q(b0));

  // 18-bit wrap-around pre-adder
  always_comb begin
    b_pre = b0;
    if (op[4]) b_pre = op[6] ? (d_r - b0) : (d_r + b0);
  end

  dsp48a1_pipe_reg #(.W(A_W), .EN(B1REG)) u_b1 (
    .clk, .rst_n, .rst(RSTB), .ce(CEB), .d(b_pre), .q(b1));

  assign m_prod = $signed(a1) * $signed(b1);

  dsp48a1_pipe_reg #(.W(M_W), .EN(MREG)) u_m (
    .clk, .rst_n, .rst(RSTM), .ce(CEM), .d(m_prod), .q(M));

  assign cin_src = (CARRYINSEL_OPMODE5 != 0) ? op[5] : CARRYIN;

  dsp48a1_pipe_reg #(.W(1), .EN(CARRYINREG)) u_cin (
    .clk, .rst_n, .rst(RSTCARRYIN), .ce(CECARRYIN), .d(cin_src), .q(cin));

  // Feedback only ever comes from the P register; without it, P selects read 0.
  generate
    if (PREG != 0) begin : g_pfb
      assign p_fb = P;
    end else begin : g_pfb_none
      assign p_fb = '0;
    end
  endgenerate

  always_comb begin
    x = '0;
    case (op[1:0])
      X_M:     x = {{(P_W-M_W){M[M_W-1]}}, M};
      X_P:     x = p_fb;
      X_DAB:   x = {d_r[11:0], a1, b1};
      default: x = '0;
    endcase
    z = '0;
    case (op[3:2])
`ifdef DSP48A1_CASCADE_EN
      Z_PCIN:  z = PCIN;
`endif
      Z_P:     z = p_fb;
      Z_C:     z = c_r;
      default: z = '0;
    endcase
  end

  assign xc = {1'b0, x} + {{P_W{1'b0}}, cin};
  assign r  = op[7] ? ({1'b0, z} - xc) : ({1'b0, z} + xc);

  dsp48a1_pipe_reg #(.W(P_W), .EN(PREG)) u_p (
    .clk, .rst_n, .rst(RSTP), .ce(CEP), .d(r[P_W-1:0]), .q(P));

  // Carry-out register shares the carry-in enable/reset, as on the silicon slice.
  dsp48a1_pipe_reg #(.W(1), .EN(CARRYOUTREG)) u_co (
    .clk, .rst_n, .rst(RSTCARRYIN), .ce(CECARRYIN), .d(r[P_W]), .q(CARRYOUT));

  assign CARRYOUTF = CARRYOUT;

`ifdef DSP48A1_CASCADE_EN
  assign PCOUT = P;
  assign BCOUT = b1;
`endif

endmodule

// File: tb/tb_dsp48a1_slice.sv
// Scoreboard bench: dut0 has only PREG, dut1 uses default pipelining.
module tb_dsp48a1_slice;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [17:0] a, b, d;
  logic [47:0] c;
  logic        carryin;
  logic [7:0]  opmode;
  logic        cea, ceb, cec, ced, cem, cep, ceopmode, cecarryin;
  logic        rsta, rstb, rstc, rstd, rstm, rstp, rstopmode, rstcarryin;
  logic [35:0] m0, m1;
  logic [47:0] p0, p1;
  logic        co0, co1, cof0, cof1;
`ifdef DSP48A1_CASCADE_EN
  logic [47:0] pcin = '0;
  logic [47:0] pcout0, pcout1;
  logic [17:0] bcout0, bcout1;
`endif

  dsp48a1_slice #(
    .A0REG(0), .A1REG(0), .B0REG(0), .B1REG(0), .CREG(0), .DREG(0), .MREG(0),
    .PREG(1), .OPMODEREG(0), .CARRYINREG(0), .CARRYOUTREG(0), .CARRYINSEL_OPMODE5(1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .D(d), .C(c), .CARRYIN(carryin),
    .OPMODE(opmode), .CEA(cea), .CEB(ceb), .CEC(cec), .CED(ced), .CEM(cem),
    .CEP(cep), .CEOPMODE(ceopmode), .CECARRYIN(cecarryin), .RSTA(rsta),
    .RSTB(rstb), .RSTC(rstc), .RSTD(rstd), .RSTM(rstm), .RSTP(rstp),
    .RSTOPMODE(rstopmode), .RSTCARRYIN(rstcarryin), .M(m0), .P(p0),
    .CARRYOUT(co0), .CARRYOUTF(cof0)
`ifdef DSP48A1_CASCADE_EN
    , .PCIN(pcin), .PCOUT(pcout0), .BCOUT(bcout0)
`endif
  );

  dsp48a1_slice dut1 (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .D(d), .C(c), .CARRYIN(carryin),
    .OPMODE(opmode), .CEA(cea), .CEB(ceb), .CEC(cec), .CED(ced), .CEM(cem),
    .CEP(cep), .CEOPMODE(ceopmode), .CECARRYIN(cecarryin), .RSTA(rsta),
    .RSTB(rstb), .RSTC(rstc), .RSTD(rstd), .RSTM(rstm), .RSTP(rstp),
    .RSTOPMODE(rstopmode), .RSTCARRYIN(rstcarryin), .M(m1), .P(p1),
    .CARRYOUT(co1), .CARRYOUTF(cof1)
`ifdef DSP48A1_CASCADE_EN
    , .PCIN(pcin), .PCOUT(pcout1), .BCOUT(bcout1)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          dut;
    int          kind;   // 0 P, 1 M, 2 CARRYOUT, 3 CARRYOUTF
    logic [47:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [47:0] mp = '0;  // reference P of dut0

  task automatic push(input int due, input int dut, input int kind, input logic [47:0] e);
    exp_t t;
    t.due = due; t.dut = dut; t.kind = kind; t.exp = e;
    sbq.push_back(t);
  endtask

  function automatic logic [47:0] actual(input int dut, input int kind);
    case ({dut[0], kind[1:0]})
      3'b000:  return p0;
      3'b001:  return {12'h0, m0};
      3'b010:  return {47'h0, co0};
      3'b011:  return {47'h0, cof0};
      3'b100:  return p1;
      3'b101:  return {12'h0, m1};
      3'b110:  return {47'h0, co1};
      default: return {47'h0, cof1};
    endcase
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      0:       return "P";
      1:       return "M";
      2:       return "CARRYOUT";
      default: return "CARRYOUTF";
    endcase
  endfunction

  // Monitor: checks every expectation whose due cycle has arrived.
  initial begin
    exp_t        e;
    logic [47:0] act;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        act = actual(e.dut, e.kind);
        n_cmp++;
        if (e.due != cyc || act !== e.exp) begin
          n_fail++;
          $display("FAIL %s dut%0d due %0d at %0d: got %h expected %h",
                   kname(e.kind), e.dut, e.due, cyc, act, e.exp);
        end
      end
    end
  end

  // Reference: P = Z +/- (X + cin) on plain integers, 49-bit wrap.
  function automatic void ref_model(input logic [7:0] op, input logic [17:0] ai, bi, di,
                                    input logic [47:0] ci, pi,
                                    output logic [48:0] r, output logic [35:0] m);
    logic [17:0] pre;
    longint      prod;
    logic [47:0] x, z;
    logic [48:0] xc;
    if (!op[4])    pre = bi;
    else if (op[6]) pre = di - bi;
    else           pre = di + bi;
    prod = longint'($signed(ai)) * longint'($signed(pre));
    m = prod[35:0];
    case (op[1:0])
      2'd0:    x = '0;
      2'd1:    x = prod[47:0];
      2'd2:    x = pi;
      default: x = {di[11:0], ai, pre};
    endcase
    case (op[3:2])
      2'd2:    z = pi;
      2'd3:    z = ci;
      default: z = '0;   // PCIN is tied to zero in this bench
    endcase
    xc = {1'b0, x} + {48'h0, op[5]};
    r  = op[7] ? ({1'b0, z} - xc) : ({1'b0, z} + xc);
  endfunction

  // Called #1 after a rising edge; leaves #1 after the next one.
  task automatic step(input logic [17:0] ai, bi, di, input logic [47:0] ci,
                      input logic [7:0] op, input bit cep_i, rstp_i,
                      input bit chk_p, chk_mc, use_exp, input logic [47:0] exp_p);
    logic [48:0] r;
    logic [35:0] m;
    logic [47:0] nxt;
    a = ai; b = bi; d = di; c = ci; opmode = op; cep = cep_i; rstp = rstp_i;
    ref_model(op, ai, bi, di, ci, mp, r, m);
    nxt = rstp_i ? 48'h0 : (cep_i ? r[47:0] : mp);
    if (chk_mc) begin
      push(cyc, 0, 1, {12'h0, m});
      push(cyc, 0, 2, {47'h0, r[48]});
      push(cyc, 0, 3, {47'h0, r[48]});
    end
    if (chk_p) push(cyc + 1, 0, 0, use_exp ? exp_p : nxt);
    mp = nxt;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    a = '0; b = '0; d = '0; c = '0; carryin = 1'b0; opmode = '0;
    {cea, ceb, cec, ced, cem, cep, ceopmode, cecarryin} = '1;
    {rsta, rstb, rstc, rstd, rstm, rstp, rstopmode, rstcarryin} = '0;

    @(posedge clk); #1;
    push(cyc, 0, 0, 48'h0); push(cyc, 0, 1, 48'h0);
    push(cyc, 0, 2, 48'h0); push(cyc, 0, 3, 48'h0);
    push(cyc, 1, 0, 48'h0); push(cyc, 1, 1, 48'h0); push(cyc, 1, 2, 48'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Default pipeline: D and OPMODE settle first, then A/B reach P via A1/B1 -> M -> P.
    opmode = 8'h11; d = 18'd2;
    repeat (3) @(posedge clk);
    #1;
    a = 18'd3; b = 18'd5;
    k = cyc;
    push(k + 1, 1, 0, 48'h0); push(k + 1, 1, 1, 48'h0);
    push(k + 2, 1, 0, 48'h0); push(k + 2, 1, 1, 48'd21);
    push(k + 3, 1, 0, 48'd21);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    a = '0; b = '0; d = '0; opmode = '0;
    push(cyc, 0, 0, 48'h0); push(cyc, 1, 0, 48'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mp = '0;

    // Load, accumulate, hold.
    step(18'd3, 18'd5, 18'd2, 48'h0, 8'h11, 1, 0, 1, 1, 1, 48'd21);
    step(18'd3, 18'd5, 18'd2, 48'h0, 8'h19, 1, 0, 1, 1, 1, 48'd42);
    step(18'd3, 18'd5, 18'd2, 48'h0, 8'h19, 1, 0, 1, 1, 1, 48'd63);
    step(18'd3, 18'd5, 18'd2, 48'h0, 8'h19, 0, 0, 1, 1, 1, 48'd63);
    step(18'd3, 18'd5, 18'd2, 48'h0, 8'h19, 0, 0, 0, 1, 0, 48'h0);

    // Async clear mid-cycle must show before the next edge.
    rst_n = 1'b0;
    mp = '0;
    push(cyc, 0, 0, 48'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    step(18'd3, 18'd5, 18'd2, 48'h0, 8'h11, 1, 0, 1, 1, 1, 48'd21);
    step(18'd3, 18'd5, 18'd2, 48'h0, 8'h19, 1, 0, 1, 1, 1, 48'd42);
    step(18'd3, 18'd5, 18'd2, 48'h0, 8'h19, 1, 1, 1, 1, 1, 48'd0);

    push(cyc, 0, 1, {12'h0, 36'hF_FFFF_FFE4});
    step(-18'sd4, 18'd7, 18'd0, 48'h0, 8'h11, 1, 0, 1, 1, 1, 48'hFFFF_FFFF_FFE4);
    step(18'd2, 18'd3, 18'd10, 48'h0, 8'h51, 1, 0, 1, 1, 1, 48'd14);
    push(cyc, 0, 2, 48'h1);
    step(18'd0, 18'd0, 18'd0, 48'hFFFF_FFFF_FFFF, 8'h2C, 1, 0, 1, 1, 1, 48'h0);

    for (int i = 0; i < 80; i++) begin
      step(18'($urandom), 18'($urandom), 18'($urandom),
           {16'($urandom), 32'($urandom)}, 8'($urandom),
           ($urandom % 8) != 0, ($urandom % 16) == 0, 1, 1, 0, 48'h0);
    end

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    if (sbq.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
